// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared state encoding and protocol byte constants for the UART register bridge
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_RD,
    RD_CAPTURE,
    SEND
  } state_t;

  localparam logic [7:0] kOpWrite = 8'h57;
  localparam logic [7:0] kOpRead  = 8'h52;
  localparam logic [7:0] kRespOk  = 8'h4B;
  localparam logic [7:0] kRespErr = 8'h3F;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == kOpWrite) || (b == kOpRead);
  endfunction

endpackage

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - byte-command bridge from a UART receiver/transmitter pair to an 8-bit register bus
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int kTimeoutCycles = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       rx_overrun
);

  localparam int kCntW = $clog2(kTimeoutCycles) + 1;
  localparam logic [kCntW-1:0] kCntLast = kCntW'(kTimeoutCycles - 1);

  state_t r_state;
  state_t w_next;

  logic [7:0]       r_opcode;
  logic [7:0]       r_addr;
  logic [7:0]       r_wdata;
  logic [7:0]       r_tx_data;
  logic             r_we;
  logic             r_overrun;
  logic [kCntW-1:0] r_cnt;

  logic w_waiting;
  logic w_accept;
  logic w_drop;
  logic w_timeout;
  logic w_ld_op;
  logic w_ld_addr;
  logic w_ld_wdata;
  logic w_ld_err;
  logic w_ld_rdata;

  // Bytes are only consumed while gathering a command; anywhere else they are lost.
  assign w_waiting = (r_state == GET_ADDR) || (r_state == GET_DATA);
  assign w_accept  = rx_valid && ((r_state == IDLE) || w_waiting);
  assign w_drop    = rx_valid && !w_accept;
  assign w_timeout = w_waiting && !rx_valid && (r_cnt == kCntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ld_op    = 1'b0;
    w_ld_addr  = 1'b0;
    w_ld_wdata = 1'b0;
    w_ld_err   = 1'b0;
    w_ld_rdata = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (is_opcode(rx_data)) begin
            w_ld_op = 1'b1;
            w_next  = GET_ADDR;
          end else begin
            w_ld_err = 1'b1;
            w_next   = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rx_valid) begin
          w_ld_addr = 1'b1;
          w_next    = (r_opcode == kOpWrite) ? GET_DATA : BUS_RD;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          w_ld_wdata = 1'b1;
          w_next     = SEND;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      BUS_RD:     w_next = RD_CAPTURE;
      RD_CAPTURE: begin
        w_ld_rdata = 1'b1;
        w_next     = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          w_next = IDLE;
        end
      end
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
      r_we      <= 1'b0;
      r_overrun <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_we      <= w_ld_wdata;
      r_overrun <= w_drop;
      if (w_ld_op) begin
        r_opcode <= rx_data;
      end
      if (w_ld_addr) begin
        r_addr <= rx_data;
      end
      if (w_ld_wdata) begin
        r_wdata <= rx_data;
      end
      // The reply byte is only ever loaded on the way into SEND, so it holds while offered.
      if (w_ld_err) begin
        r_tx_data <= kRespErr;
      end else if (w_ld_wdata) begin
        r_tx_data <= kRespOk;
      end else if (w_ld_rdata) begin
        r_tx_data <= reg_rdata;
      end
      if (!w_waiting || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + kCntW'(1);
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = (r_state == SEND);
  assign reg_addr   = r_addr;
  assign reg_wdata  = r_wdata;
  assign reg_we     = r_we;
  assign reg_re     = (r_state == BUS_RD);
  assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb/tb_uart_reg_bridge.sv - randomized self-checking bench for uart_reg_bridge against a command-level model
module tb_uart_reg_bridge;

  localparam logic [7:0] W_OP = 8'h57;
  localparam logic [7:0] R_OP = 8'h52;
  localparam logic [7:0] OK_B = 8'h4B;
  localparam logic [7:0] ER_B = 8'h3F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       rx_overrun;

  always #5 clk = ~clk;

  uart_reg_bridge #(.kTimeoutCycles(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .rx_overrun(rx_overrun)
  );

  // Register slave: data valid only in the cycle after reg_re, a wrong value otherwise.
  logic [7:0] rd_mem [256];
  always @(posedge clk) reg_rdata <= reg_re ? rd_mem[reg_addr] : ~rd_mem[reg_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  txq[$];
  int ovr_cnt = 0, both_err = 0, stab_err = 0, we_len_err = 0, tx_rise_cyc = 0;
  logic p_valid = 1'b0, p_xfer = 1'b0, p_we = 1'b0;
  logic [7:0] p_data = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) wq.push_back({reg_addr, reg_wdata});
      if (reg_re) rq.push_back(reg_addr);
      if (reg_we && reg_re) both_err++;
      if (reg_we && p_we) we_len_err++;
      if (tx_valid && !p_valid) tx_rise_cyc = cyc;
      if (p_valid && !p_xfer && (!tx_valid || tx_data !== p_data)) stab_err++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (rx_overrun) ovr_cnt++;
      p_valid = tx_valid;
      p_xfer  = tx_valid && tx_ready;
      p_data  = tx_data;
      p_we    = reg_we;
    end else begin
      p_valid = 1'b0;
      p_xfer  = 1'b0;
      p_we    = 1'b0;
    end
  end

  int n_checks = 0, n_pass = 0;
  int last_cyc = 0;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (txq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx_valid, reg_we, reg_re, rx_overrun} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000", {tx_valid, reg_we, reg_re, rx_overrun});
    else n_pass++;
    n_checks++;
    if ({tx_data, reg_addr, reg_wdata} !== 24'h0)
      $display("FAIL reset_data: got %h expected 000000", {tx_data, reg_addr, reg_wdata});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({tx_valid, reg_we, reg_re, rx_overrun} !== 4'b0000)
      $display("FAIL reset_release_idle: got %b expected 0000", {tx_valid, reg_we, reg_re, rx_overrun});
    else n_pass++;
  endtask

  task automatic test_write();
    int w0 = wq.size(), r0 = rq.size(), t0 = txq.size();
    bit ok;
    send_byte(W_OP); send_byte(8'h10); send_byte(8'hA5);
    wait_tx(t0 + 1, ok);
    n_checks++;
    if (!ok) $display("FAIL write_reply_timeout: got no reply expected 1 byte");
    else n_pass++;
    n_checks++;
    if (wq.size() != w0 + 1 || rq.size() != r0)
      $display("FAIL write_bus_count: got we=%0d re=%0d expected we=1 re=0", wq.size() - w0, rq.size() - r0);
    else n_pass++;
    n_checks++;
    if (wq.size() != w0 + 1 || wq[w0] !== 16'h10A5)
      $display("FAIL write_bus_value: got %h expected 10a5", (wq.size() > w0) ? wq[w0] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (!ok || txq[t0] !== OK_B) $display("FAIL write_reply: got %h expected %h", ok ? txq[t0] : 8'hxx, OK_B);
    else n_pass++;
    n_checks++;
    if (tx_rise_cyc - last_cyc < 1 || tx_rise_cyc - last_cyc > 3)
      $display("FAIL write_latency: got %0d expected 1..3", tx_rise_cyc - last_cyc);
    else n_pass++;
  endtask

  task automatic test_read();
    int w0 = wq.size(), r0 = rq.size(), t0 = txq.size();
    bit ok;
    send_byte(R_OP); send_byte(8'h22);
    wait_tx(t0 + 1, ok);
    n_checks++;
    if (!ok || txq[t0] !== 8'h3C) $display("FAIL read_reply: got %h expected 3c", ok ? txq[t0] : 8'hxx);
    else n_pass++;
    n_checks++;
    if (wq.size() != w0 || rq.size() != r0 + 1 || rq[r0] !== 8'h22)
      $display("FAIL read_bus: got we=%0d re=%0d expected we=0 re=1 at 22", wq.size() - w0, rq.size() - r0);
    else n_pass++;
    n_checks++;
    if (tx_rise_cyc - last_cyc < 1 || tx_rise_cyc - last_cyc > 3)
      $display("FAIL read_latency: got %0d expected 1..3", tx_rise_cyc - last_cyc);
    else n_pass++;
  endtask

  task automatic test_bad_opcode();
    int w0 = wq.size(), r0 = rq.size(), t0 = txq.size();
    bit ok;
    send_byte(8'h41);
    wait_tx(t0 + 1, ok);
    n_checks++;
    if (!ok || txq[t0] !== ER_B || wq.size() != w0 || rq.size() != r0)
      $display("FAIL bad_opcode: got reply %h bus %0d expected %h bus 0", ok ? txq[t0] : 8'hxx,
               wq.size() - w0 + rq.size() - r0, ER_B);
    else n_pass++;
    send_byte(R_OP); send_byte(8'h01);
    wait_tx(t0 + 2, ok);
    n_checks++;
    if (!ok || txq[t0+1] !== rd_mem[1] || rq.size() != r0 + 1 || rq[r0] !== 8'h01)
      $display("FAIL after_bad_read: got %h expected %h", ok ? txq[t0+1] : 8'hxx, rd_mem[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    int w0 = wq.size(), r0 = rq.size(), t0 = txq.size();
    logic [15:0] ew[$];
    logic [7:0]  er[$];
    logic [7:0]  et[$];
    int lat_bad = 0;
    bit ok;
    for (int n = 0; n < 24; n++) begin
      int kind = $urandom_range(0, 2);
      logic [7:0] a = 8'($urandom);
      logic [7:0] d = 8'($urandom);
      logic [7:0] op = 8'($urandom);
      tx_ready = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        send_byte(W_OP); repeat ($urandom_range(0, 3)) @(posedge clk);
        send_byte(a);    repeat ($urandom_range(0, 3)) @(posedge clk);
        send_byte(d);
        ew.push_back({a, d}); et.push_back(OK_B);
      end else if (kind == 1) begin
        send_byte(R_OP); repeat ($urandom_range(0, 3)) @(posedge clk);
        send_byte(a);
        er.push_back(a); et.push_back(rd_mem[a]);
      end else begin
        while (op == W_OP || op == R_OP) op = 8'($urandom);
        send_byte(op);
        et.push_back(ER_B);
      end
      if (!tx_ready) begin
        for (int i = 0; i < 10 && !tx_valid; i++) begin @(posedge clk); #1; end
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
      wait_tx(t0 + et.size(), ok);
      if (tx_rise_cyc - last_cyc < 1 || tx_rise_cyc - last_cyc > 3) lat_bad++;
      if (!ok) break;
    end
    n_checks++;
    if (txq.size() - t0 != et.size() || wq.size() - w0 != ew.size() || rq.size() - r0 != er.size())
      $display("FAIL rand_counts: got tx=%0d we=%0d re=%0d expected tx=%0d we=%0d re=%0d",
               txq.size() - t0, wq.size() - w0, rq.size() - r0, et.size(), ew.size(), er.size());
    else n_pass++;
    for (int i = 0; i < et.size() && t0 + i < txq.size(); i++) begin
      n_checks++;
      if (txq[t0+i] !== et[i]) $display("FAIL rand_reply[%0d]: got %h expected %h", i, txq[t0+i], et[i]);
      else n_pass++;
    end
    for (int i = 0; i < ew.size() && w0 + i < wq.size(); i++) begin
      n_checks++;
      if (wq[w0+i] !== ew[i]) $display("FAIL rand_write[%0d]: got %h expected %h", i, wq[w0+i], ew[i]);
      else n_pass++;
    end
    for (int i = 0; i < er.size() && r0 + i < rq.size(); i++) begin
      n_checks++;
      if (rq[r0+i] !== er[i]) $display("FAIL rand_read[%0d]: got %h expected %h", i, rq[r0+i], er[i]);
      else n_pass++;
    end
    n_checks++;
    if (lat_bad != 0) $display("FAIL rand_latency: got %0d late replies expected 0", lat_bad);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int w0 = wq.size(), r0 = rq.size(), t0 = txq.size();
    bit ok;
    // Byte arriving in the very cycle the counter expires still completes the write.
    send_byte(W_OP); send_byte(8'h44);
    repeat (98) @(posedge clk);
    send_byte(8'h5A);
    wait_tx(t0 + 1, ok);
    n_checks++;
    if (!ok || txq[t0] !== OK_B || wq.size() != w0 + 1 || wq[w0] !== 16'h445A)
      $display("FAIL timeout_edge_write: got reply %h writes %0d expected %h 1", ok ? txq[t0] : 8'hxx,
               wq.size() - w0, OK_B);
    else n_pass++;
    // One cycle later the command has been abandoned and the byte is a fresh opcode.
    send_byte(W_OP); send_byte(8'h10);
    repeat (99) @(posedge clk);
    n_checks++;
    if (txq.size() != t0 + 1 || wq.size() != w0 + 1)
      $display("FAIL timeout_silent: got tx=%0d we=%0d expected tx=0 we=0", txq.size() - t0 - 1, wq.size() - w0 - 1);
    else n_pass++;
    send_byte(R_OP); send_byte(8'h10);
    wait_tx(t0 + 2, ok);
    n_checks++;
    if (!ok || txq[t0+1] !== rd_mem[8'h10] || wq.size() != w0 + 1 || rq.size() != r0 + 1)
      $display("FAIL timeout_then_read: got %h expected %h", ok ? txq[t0+1] : 8'hxx, rd_mem[8'h10]);
    else n_pass++;
    send_byte(W_OP);
    repeat (99) @(posedge clk);
    send_byte(8'h41);
    wait_tx(t0 + 3, ok);
    n_checks++;
    if (!ok || txq[t0+2] !== ER_B) $display("FAIL addr_timeout: got %h expected %h", ok ? txq[t0+2] : 8'hxx, ER_B);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int w0 = wq.size(), t0 = txq.size(), o0 = ovr_cnt, s0 = stab_err;
    bit ok;
    tx_ready = 1'b0;
    send_byte(R_OP); send_byte(8'h22);
    for (int i = 0; i < 10 && !tx_valid; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      rx_valid = (i == 10);
      rx_data  = W_OP;
    end
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h3C || txq.size() != t0)
      $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=3c", tx_valid, tx_data);
    else n_pass++;
    n_checks++;
    if (ovr_cnt - o0 != 1) $display("FAIL bp_overrun: got %0d pulses expected 1", ovr_cnt - o0);
    else n_pass++;
    tx_ready = 1'b1;
    wait_tx(t0 + 1, ok);
    n_checks++;
    if (!ok || txq[t0] !== 8'h3C || stab_err != s0)
      $display("FAIL bp_transfer: got %h unstable=%0d expected 3c unstable=0", ok ? txq[t0] : 8'hxx, stab_err - s0);
    else n_pass++;
    send_byte(8'h41);
    wait_tx(t0 + 2, ok);
    n_checks++;
    if (!ok || txq[t0+1] !== ER_B || wq.size() != w0)
      $display("FAIL bp_dropped_byte: got %h writes %0d expected %h 0", ok ? txq[t0+1] : 8'hxx, wq.size() - w0, ER_B);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0 = wq.size(), t0 = txq.size();
    bit ok;
    send_byte(W_OP); send_byte(8'h10);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (wq.size() != w0 || txq.size() != t0 || reg_addr !== 8'h00)
      $display("FAIL reset_mid_abandon: got we=%0d tx=%0d addr=%h expected 0 0 00", wq.size() - w0, txq.size() - t0, reg_addr);
    else n_pass++;
    send_byte(W_OP); send_byte(8'h20); send_byte(8'hFF);
    wait_tx(t0 + 1, ok);
    n_checks++;
    if (!ok || txq[t0] !== OK_B || wq.size() != w0 + 1 || wq[w0] !== 16'h20FF)
      $display("FAIL reset_mid_next_write: got %h writes %0d expected %h 1 at 20ff", ok ? txq[t0] : 8'hxx,
               wq.size() - w0, OK_B);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    rd_mem[8'h22] = 8'h3C;
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_random();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    n_checks++;
    if (both_err != 0 || we_len_err != 0 || stab_err != 0)
      $display("FAIL bus_rules: got both=%0d long_we=%0d unstable=%0d expected 0 0 0", both_err, we_len_err, stab_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 Parameter kTimeoutCycles, default 1_000_000, inter-byte timeout in clk cycles (10 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  received byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-006 tx_data  output  8  response byte to UART transmitter.
REQ-007 tx_valid  output  1  response byte offered.
REQ-008 tx_ready  input  1  transmitter idle/accepting.
REQ-009 reg_addr  output  8  register bus address.
REQ-010 reg_wdata  output  8  register bus write data.
REQ-011 reg_we  output  1  one-cycle write strobe.
REQ-012 reg_re  output  1  one-cycle read strobe.
REQ-013 reg_rdata  input  8  read data, valid exactly one cycle after reg_re.
REQ-014 rx_overrun  output  1  one-cycle pulse, rx byte dropped.

Function
REQ-015 Protocol: write = 0x57 'W', addr, data -> reply 0x4B 'K'; read = 0x52 'R', addr -> reply one byte reg_rdata.
REQ-016 Any other first byte SHALL produce reply 0x3F '?' with no bus access.
REQ-017 States: IDLE, GET_ADDR, GET_DATA, BUS_RD, RD_CAPTURE, SEND.
REQ-018 IDLE + rx_valid: 'W' or 'R' -> GET_ADDR, latch opcode; other -> SEND with tx_data=0x3F.
REQ-019 GET_ADDR + rx_valid: latch reg_addr; opcode W -> GET_DATA; opcode R -> BUS_RD.
REQ-020 GET_DATA + rx_valid: latch reg_wdata, assert reg_we for exactly the next cycle, set tx_data=0x4B, go to SEND.
REQ-021 BUS_RD: reg_re high for exactly one cycle -> RD_CAPTURE; RD_CAPTURE samples reg_rdata into tx_data -> SEND.
REQ-022 SEND: tx_valid high; transfer occurs in a cycle with tx_valid && tx_ready; next cycle tx_valid=0, state IDLE.
REQ-023 tx_data SHALL stay stable while tx_valid is high.
REQ-024 Latency: last command byte strobe to tx_valid high <= 3 cycles.
REQ-025 rx_valid in BUS_RD, RD_CAPTURE or SEND: byte discarded, rx_overrun pulses the following cycle; state unaffected.
REQ-026 Timeout counter: cleared on every accepted byte and on entry to GET_ADDR; increments in GET_ADDR/GET_DATA only.
REQ-027 Counter reaching kTimeoutCycles-1 without rx_valid -> IDLE, no reply, no bus strobe.
REQ-028 rx_valid in the same cycle as timeout expiry: byte wins, timeout ignored.
REQ-029 reg_we and reg_re SHALL never be high in the same cycle; each pulse exactly one cycle per command.
REQ-030 Counter width = $clog2(kTimeoutCycles)+1; no wrap possible.

Reset
REQ-031 rst_n low: state IDLE, tx_valid=0, tx_data=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, rx_overrun=0, timeout counter 0.
REQ-032 Reset asserted mid-command or mid-SEND SHALL abandon the transaction with no further strobes after release.
REQ-033 First rx_valid after reset release SHALL be treated as a command opcode.

Structure
REQ-034 Package uart_bridge_pkg holds the state enum and opcode/reply byte constants (0x57, 0x52, 0x4B, 0x3F).
REQ-035 Single module, no sub-modules; it sits between the UART receiver outputs and the UART transmitter inputs.

Verification
REQ-036 Bytes 57,10,A5 -> reg_we one cycle with addr=0x10, wdata=0xA5; then tx_valid with tx_data=0x4B.
REQ-037 Bytes 52,22 with bench returning 0x3C one cycle after reg_re -> tx_data=0x3C transmitted, no reg_we.
REQ-038 Byte 0x41 -> tx_data=0x3F, no reg_re/reg_we; next 52,01 handled normally.
REQ-039 kTimeoutCycles=100: send 57,10 then idle 100 cycles -> back to IDLE, no reply; then 52,10 works.
REQ-040 tx_ready held low 50 cycles during SEND plus rx_valid pulse -> tx_valid/tx_data stable, rx_overrun one pulse, byte dropped.
REQ-041 rst_n pulsed low after 57,10 -> no reg_we ever; subsequent 57,20,FF writes addr 0x20.
